// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: dual-slot gshare PHT + tagged BTB fetch predictor with registered next PC.
// Define BTB_NT_EVICT_EN to drop BTB entries whose counter saturates not-taken.
module gshare_btb_predictor #(
    parameter int ENTRY_BITS = 8,
    parameter int GHR_BITS   = 8,
    parameter int TAG_BITS   = 20
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [31:0]         pc_i,
    input  logic                lookup_i,
    output logic                ready_o,
    output logic                pred_valid_o,
    output logic                pred_taken_0_o,
    output logic                pred_taken_1_o,
    output logic [31:0]         next_pc_o,
    output logic [GHR_BITS-1:0] ghr_o,
    input  logic                upd_valid_i,
    input  logic [31:0]         upd_pc_i,
    input  logic                upd_taken_i,
    input  logic [31:0]         upd_target_i,
    input  logic [GHR_BITS-1:0] upd_ghr_i,
    input  logic                mispredict_i
);
    localparam int N = 1 << ENTRY_BITS;

    typedef enum logic {INIT, READY} state_t;

    state_t state_q, state_d;
    logic [ENTRY_BITS-1:0] cnt_q, cnt_d;
    logic [GHR_BITS-1:0] ghr_q, ghr_d, ghr_out_q, ghr_out_d;
    logic ready_q, ready_d, valid_q, valid_d, taken0_q, taken0_d, taken1_q, taken1_d;
    logic [31:0] npc_q, npc_d;

    logic [1:0] pht [N];
    logic btb_valid [N];
    logic [TAG_BITS-1:0] btb_tag [N];
    logic [31:0] btb_target [N];

    logic [31:0] pc1;
    logic [ENTRY_BITS-1:0] ghr_ext, ughr_ext, bidx0, bidx1, pidx0, pidx1, ubidx, upidx;
    logic [TAG_BITS-1:0] tag0, tag1, utag;
    logic hit0, hit1, t0, t1;
    logic init, acc, upd, rep, evict;
    logic [1:0] pht_cur, pht_inc, pht_dec;
    logic pht_we, bv_we, bv_wd, be_we;
    logic [ENTRY_BITS-1:0] pht_wa, bv_wa;
    logic [1:0] pht_wd;
    logic [GHR_BITS:0] ghr_shift, ghr_fix;
    logic unused_bits;

    assign pc1       = pc_i + 32'd4;
    assign ghr_ext   = ENTRY_BITS'(ghr_q);
    assign ughr_ext  = ENTRY_BITS'(upd_ghr_i);
    assign bidx0     = pc_i[ENTRY_BITS+1:2];
    assign bidx1     = pc1[ENTRY_BITS+1:2];
    assign ubidx     = upd_pc_i[ENTRY_BITS+1:2];
    assign pidx0     = bidx0 ^ ghr_ext;
    assign pidx1     = bidx1 ^ ghr_ext;
    assign upidx     = ubidx ^ ughr_ext;
    assign tag0      = pc_i[ENTRY_BITS+TAG_BITS+1 -: TAG_BITS];
    assign tag1      = pc1[ENTRY_BITS+TAG_BITS+1 -: TAG_BITS];
    assign utag      = upd_pc_i[ENTRY_BITS+TAG_BITS+1 -: TAG_BITS];
    assign unused_bits = ^{pc1, pc_i, upd_pc_i};

    // Reads are combinational on current contents, so a same-edge write is seen next cycle.
    always_comb begin
        hit0      = btb_valid[bidx0] && btb_tag[bidx0] == tag0;
        hit1      = btb_valid[bidx1] && btb_tag[bidx1] == tag1;
        t0        = hit0 && pht[pidx0][1];
        t1        = hit1 && pht[pidx1][1];
        init      = state_q == INIT;
        acc       = lookup_i && !init;
        upd       = upd_valid_i && !init;
        rep       = mispredict_i && !init;
        pht_cur   = pht[upidx];
        pht_inc   = pht_cur == 2'b11 ? 2'b11 : pht_cur + 2'd1;
        pht_dec   = pht_cur == 2'b00 ? 2'b00 : pht_cur - 2'd1;
`ifdef BTB_NT_EVICT_EN
        evict     = upd && !upd_taken_i && pht_dec == 2'b00 && btb_valid[ubidx] && btb_tag[ubidx] == utag;
`else
        evict     = 1'b0;
`endif
        pht_we    = init || upd;
        pht_wa    = init ? cnt_q : upidx;
        pht_wd    = init ? 2'b01 : upd_taken_i ? pht_inc : pht_dec;
        be_we     = upd && upd_taken_i;
        bv_we     = init || be_we || evict;
        bv_wa     = init ? cnt_q : ubidx;
        bv_wd     = !init && upd_taken_i;
        state_d   = init && &cnt_q ? READY : state_q;
        cnt_d     = init ? cnt_q + 1'b1 : cnt_q;
        ready_d   = state_d == READY;
        valid_d   = acc;
        taken0_d  = acc ? t0 : taken0_q;
        taken1_d  = acc ? t1 : taken1_q;
        npc_d     = acc ? (t0 ? btb_target[bidx0] : t1 ? btb_target[bidx1] : pc_i + 32'd8) : npc_q;
        ghr_out_d = acc ? ghr_q : ghr_out_q;
        ghr_shift = {ghr_q, t0 | t1};
        ghr_fix   = {upd_ghr_i, upd_taken_i};
        ghr_d     = rep ? ghr_fix[GHR_BITS-1:0] : acc ? ghr_shift[GHR_BITS-1:0] : ghr_q;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            ghr_q     <= '0;
            ghr_out_q <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            taken0_q  <= 1'b0;
            taken1_q  <= 1'b0;
            npc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ghr_q     <= ghr_d;
            ghr_out_q <= ghr_out_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            taken0_q  <= taken0_d;
            taken1_q  <= taken1_d;
            npc_q     <= npc_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (pht_we) pht[pht_wa] <= pht_wd;
        if (bv_we) btb_valid[bv_wa] <= bv_wd;
        if (be_we) begin
            btb_tag[ubidx]    <= utag;
            btb_target[ubidx] <= upd_target_i;
        end
    end

    assign ready_o        = ready_q;
    assign pred_valid_o   = valid_q;
    assign pred_taken_0_o = taken0_q;
    assign pred_taken_1_o = taken1_q;
    assign next_pc_o      = npc_q;
    assign ghr_o          = ghr_out_q;
endmodule
